// File: rtl/dmem_ctrl_if.sv
// Data bus between the load/store controller and the memory fabric.
// Single outstanding request: valid/ready request phase, then an rvalid response phase.
interface dmem_ctrl_if;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_err;

  modport master (
    output mem_valid, mem_addr, mem_wstrb, mem_wdata,
    input  mem_ready, mem_rvalid, mem_rdata, mem_err
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wstrb, mem_wdata,
    output mem_ready, mem_rvalid, mem_rdata, mem_err
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Load/store data-memory controller: one aligned access at a time, load extraction and access faults.
// Optional macro DMEM_TIMEOUT_EN forces an access fault after TIMEOUT_CYCLES silent WAIT cycles.
module dmem_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_load,
  input  logic          req_store,
  input  logic [2:0]    req_op,
  input  logic [31:0]   req_addr,
  input  logic [3:0]    req_byteenable,
  input  logic [31:0]   req_wdata,
  input  logic          flush,
  dmem_ctrl_if.master   bus,
  output logic          resp_valid,
  output logic [31:0]   resp_rdata,
  output logic          resp_exception,
  output logic [3:0]    resp_ecause,
  output logic [31:0]   resp_etval,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state_reg, state_next;
  logic [31:0] mem_addr_reg, mem_wdata_reg, byte_addr_reg;
  logic [3:0]  mem_wstrb_reg;
  logic [2:0]  op_reg;
  logic        is_store_reg, suppress_reg;
  logic        resp_valid_reg, resp_exception_reg;
  logic [31:0] resp_rdata_reg, resp_etval_reg;
  logic [3:0]  resp_ecause_reg;

  logic        accept, timeout_hit, complete, fault;
  logic [31:0] wdata_rep, lane, load_data;

  assign req_ready = (state_reg == IDLE) & ~flush & ~reset;
  assign accept    = req_valid & req_ready & (req_load | req_store) & (|req_byteenable);
  assign busy      = (state_reg != IDLE);

  assign bus.mem_valid = (state_reg == REQ);
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wstrb = mem_wstrb_reg;
  assign bus.mem_wdata = mem_wdata_reg;

  assign resp_valid     = resp_valid_reg;
  assign resp_rdata     = resp_rdata_reg;
  assign resp_exception = resp_exception_reg;
  assign resp_ecause    = resp_ecause_reg;
  assign resp_etval     = resp_etval_reg;

`ifdef DMEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] wait_cnt_reg;

  assign timeout_hit = (state_reg == WAIT) & ~bus.mem_rvalid &
                       (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      wait_cnt_reg <= '0;
    else if (state_reg == REQ)
      wait_cnt_reg <= '0;
    else if (state_reg == WAIT && !bus.mem_rvalid)
      wait_cnt_reg <= wait_cnt_reg + 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign complete = (state_reg == WAIT) & (bus.mem_rvalid | timeout_hit);
  // A timeout without rvalid is reported exactly like a bus error.
  assign fault    = bus.mem_rvalid ? bus.mem_err : 1'b1;

  always_comb begin
    wdata_rep = req_wdata;
    case (req_op[1:0])
      2'b00:   wdata_rep = {4{req_wdata[7:0]}};
      2'b01:   wdata_rep = {2{req_wdata[15:0]}};
      default: wdata_rep = req_wdata;
    endcase
  end

  assign lane = bus.mem_rdata >> {byte_addr_reg[1:0], 3'b000};

  always_comb begin
    load_data = lane;
    case (op_reg)
      3'b000:  load_data = {{24{lane[7]}}, lane[7:0]};
      3'b100:  load_data = {24'b0, lane[7:0]};
      3'b001:  load_data = {{16{lane[15]}}, lane[15:0]};
      3'b101:  load_data = {16'b0, lane[15:0]};
      default: load_data = lane;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = REQ;
      REQ: begin
        if (bus.mem_ready)  state_next = WAIT;
        else if (flush)     state_next = IDLE;
      end
      WAIT: if (complete) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_addr_reg       <= '0;
      mem_wdata_reg      <= '0;
      mem_wstrb_reg      <= '0;
      byte_addr_reg      <= '0;
      op_reg             <= '0;
      is_store_reg       <= 1'b0;
      suppress_reg       <= 1'b0;
      resp_valid_reg     <= 1'b0;
      resp_exception_reg <= 1'b0;
      resp_rdata_reg     <= '0;
      resp_etval_reg     <= '0;
      resp_ecause_reg    <= '0;
    end else begin
      resp_valid_reg     <= 1'b0;
      resp_exception_reg <= 1'b0;
      resp_rdata_reg     <= '0;
      resp_etval_reg     <= '0;
      resp_ecause_reg    <= '0;

      if (accept) begin
        mem_addr_reg  <= {req_addr[31:2], 2'b00};
        mem_wstrb_reg <= req_store ? req_byteenable : 4'b0;
        mem_wdata_reg <= wdata_rep;
        byte_addr_reg <= req_addr;
        op_reg        <= req_op;
        is_store_reg  <= req_store;
      end

      // A flush during the bus handshake or while waiting kills the eventual response.
      if (state_reg == REQ && bus.mem_ready)
        suppress_reg <= flush;
      else if (state_reg == WAIT && flush)
        suppress_reg <= 1'b1;

      if (complete) begin
        suppress_reg <= 1'b0;
        if (!(suppress_reg | flush)) begin
          resp_valid_reg <= 1'b1;
          if (fault) begin
            resp_exception_reg <= 1'b1;
            resp_ecause_reg    <= is_store_reg ? 4'd7 : 4'd5;
            resp_etval_reg     <= byte_addr_reg;
          end else begin
            resp_rdata_reg     <= is_store_reg ? 32'b0 : load_data;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed testbench for dmem_ctrl: load extraction, stores, stalls, faults, flushes and timeout.
module tb_dmem_ctrl;
  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_load, req_store, flush;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_byteenable;
  logic        resp_valid, resp_exception, busy;
  logic [31:0] resp_rdata, resp_etval;
  logic [3:0]  resp_ecause;

  int checks   = 0;
  int failures = 0;

  dmem_ctrl_if bus();

  dmem_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_load       (req_load),
    .req_store      (req_store),
    .req_op         (req_op),
    .req_addr       (req_addr),
    .req_byteenable (req_byteenable),
    .req_wdata      (req_wdata),
    .flush          (flush),
    .bus            (bus.master),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_exception (resp_exception),
    .resp_ecause    (resp_ecause),
    .resp_etval     (resp_etval),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic ld, input logic st, input logic [2:0] op,
                       input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
    req_valid      = 1'b1;
    req_load       = ld;
    req_store      = st;
    req_op         = op;
    req_addr       = addr;
    req_byteenable = be;
    req_wdata      = wd;
  endtask

  task automatic idle_req();
    req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
    req_op = 3'b0; req_addr = '0; req_byteenable = '0; req_wdata = '0;
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    idle_req();
    bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0; bus.mem_err = 1'b0;
    step(); step();
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    #1;
    check("idle_req_ready", 32'(req_ready), 32'd1);
    step();

    // LB 0x103: byte lane 3 of 0x80FF1234 is 0x80 -> sign-extended
    issue(1'b1, 1'b0, 3'b000, 32'h103, 4'h8, 32'h0);
    bus.mem_ready = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h80FF_1234;
    step(); idle_req();
    check("lb_mem_valid", 32'(bus.mem_valid), 32'd1);
    check("lb_mem_addr", bus.mem_addr, 32'h100);
    check("lb_mem_wstrb", 32'(bus.mem_wstrb), 32'h0);
    check("lb_busy", 32'(busy), 32'd1);
    step();
    check("lb_resp_early", 32'(resp_valid), 32'd0);
    step();
    check("lb_resp_valid", 32'(resp_valid), 32'd1);
    check("lb_resp_rdata", resp_rdata, 32'hFFFF_FF80);
    check("lb_resp_exc", 32'(resp_exception), 32'd0);
    step();
    check("lb_resp_pulse", 32'(resp_valid), 32'd0);
    check("lb_rdata_zero", resp_rdata, 32'h0);

    // SH 0x202: halfword replicated, upper strobes
    issue(1'b0, 1'b1, 3'b001, 32'h202, 4'hC, 32'h0000_ABCD);
    bus.mem_rdata = 32'hDEAD_BEEF;
    step(); idle_req();
    check("sh_mem_addr", bus.mem_addr, 32'h200);
    check("sh_mem_wdata", bus.mem_wdata, 32'hABCD_ABCD);
    check("sh_mem_wstrb", 32'(bus.mem_wstrb), 32'hC);
    step(); step();
    check("sh_resp_valid", 32'(resp_valid), 32'd1);
    check("sh_resp_rdata", resp_rdata, 32'h0);
    check("sh_resp_exc", 32'(resp_exception), 32'd0);

    // SB replication
    issue(1'b0, 1'b1, 3'b000, 32'h301, 4'h2, 32'h1234_5677);
    step(); idle_req();
    check("sb_mem_wdata", bus.mem_wdata, 32'h7777_7777);
    check("sb_mem_wstrb", 32'(bus.mem_wstrb), 32'h2);
    step(); step();
    check("sb_resp_valid", 32'(resp_valid), 32'd1);

    // LHU 0x2 with mem_ready low for 4 cycles
    bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0;
    issue(1'b1, 1'b0, 3'b101, 32'h2, 4'hC, 32'h0);
    step(); idle_req();
    for (int i = 0; i < 4; i++) begin
      check("lhu_stall_valid", 32'(bus.mem_valid), 32'd1);
      check("lhu_stall_addr", bus.mem_addr, 32'h0);
      if (i < 3) step();
    end
    bus.mem_ready = 1'b1;
    step();
    bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h9876_0000;
    check("lhu_wait_valid", 32'(bus.mem_valid), 32'd0);
    step();
    bus.mem_rvalid = 1'b0;
    check("lhu_resp_valid", 32'(resp_valid), 32'd1);
    check("lhu_resp_rdata", resp_rdata, 32'h0000_9876);

    // LW 0x40 bus error -> load access fault
    bus.mem_ready = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_err = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
    issue(1'b1, 1'b0, 3'b010, 32'h40, 4'hF, 32'h0);
    step(); idle_req(); step(); step();
    check("lw_err_valid", 32'(resp_valid), 32'd1);
    check("lw_err_exc", 32'(resp_exception), 32'd1);
    check("lw_err_ecause", 32'(resp_ecause), 32'd5);
    check("lw_err_etval", resp_etval, 32'h40);
    check("lw_err_rdata", resp_rdata, 32'h0);

    // SW 0x44 bus error -> store access fault
    issue(1'b0, 1'b1, 3'b010, 32'h44, 4'hF, 32'h5555_AAAA);
    step(); idle_req(); step(); step();
    check("sw_err_exc", 32'(resp_exception), 32'd1);
    check("sw_err_ecause", 32'(resp_ecause), 32'd7);
    check("sw_err_etval", resp_etval, 32'h44);
    bus.mem_err = 1'b0;
    step();
    check("err_clear_exc", 32'(resp_exception), 32'd0);
    check("err_clear_ecause", 32'(resp_ecause), 32'd0);

    // Flush in WAIT, rvalid two cycles later
    bus.mem_rvalid = 1'b0;
    issue(1'b1, 1'b0, 3'b010, 32'h80, 4'hF, 32'h0);
    step(); idle_req(); step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fw_busy_hold", 32'(busy), 32'd1);
    step();
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1111_2222;
    step();
    bus.mem_rvalid = 1'b0;
    check("fw_no_resp", 32'(resp_valid), 32'd0);
    check("fw_idle", 32'(busy), 32'd0);

    // Next request still accepted: LBU 0x1 -> 0xAB
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0000_AB00;
    issue(1'b1, 1'b0, 3'b100, 32'h1, 4'h2, 32'h0);
    step(); idle_req();
    check("fw_next_accept", 32'(bus.mem_valid), 32'd1);
    step(); step();
    check("lbu_resp_valid", 32'(resp_valid), 32'd1);
    check("lbu_resp_rdata", resp_rdata, 32'h0000_00AB);

    // Flush in REQ with mem_ready low
    bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0;
    issue(1'b1, 1'b0, 3'b010, 32'h100, 4'hF, 32'h0);
    step(); idle_req();
    check("fr_mem_valid", 32'(bus.mem_valid), 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fr_valid_drop", 32'(bus.mem_valid), 32'd0);
    check("fr_busy", 32'(busy), 32'd0);
    step();
    check("fr_no_resp", 32'(resp_valid), 32'd0);

    // Flush in IDLE blocks acceptance
    bus.mem_ready = 1'b1;
    issue(1'b1, 1'b0, 3'b010, 32'h10, 4'hF, 32'h0);
    flush = 1'b1;
    #1;
    check("fi_req_ready", 32'(req_ready), 32'd0);
    step(); idle_req(); flush = 1'b0;
    check("fi_no_access", 32'(bus.mem_valid), 32'd0);

    // Byteenable 0 load: consumed, no access
    issue(1'b1, 1'b0, 3'b010, 32'h21, 4'h0, 32'h0);
    #1;
    check("be0_req_ready", 32'(req_ready), 32'd1);
    step(); idle_req();
    check("be0_no_access", 32'(bus.mem_valid), 32'd0);
    check("be0_busy", 32'(busy), 32'd0);
    step();
    check("be0_no_resp", 32'(resp_valid), 32'd0);

    // Silent WAIT: timeout fault or indefinite wait
    bus.mem_ready = 1'b1; bus.mem_rvalid = 1'b0;
    issue(1'b1, 1'b0, 3'b010, 32'h60, 4'hF, 32'h0);
    step(); idle_req();
    step();
`ifdef DMEM_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      check("to_pending", 32'(resp_valid), 32'd0);
      step();
    end
    check("to_resp_valid", 32'(resp_valid), 32'd1);
    check("to_resp_exc", 32'(resp_exception), 32'd1);
    check("to_resp_ecause", 32'(resp_ecause), 32'd5);
    check("to_resp_etval", resp_etval, 32'h60);
    check("to_idle", 32'(busy), 32'd0);
`else
    for (int i = 0; i < 10; i++) step();
    check("nt_still_busy", 32'(busy), 32'd1);
    check("nt_no_resp", 32'(resp_valid), 32'd0);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
    step();
    bus.mem_rvalid = 1'b0;
    check("nt_late_resp", resp_rdata, 32'hCAFE_F00D);
`endif
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory side of the load/store path.
- Takes one aligned access per request: byte address, byte enables and access type, as produced by address generation in execute.
- Drives a single-outstanding valid/ready data bus and returns the load result, extracted and sign- or zero-extended, or an access-fault exception to writeback.
- Sits between execute and the data memory/bus fabric; raises busy so the pipeline stalls while an access is in flight.

Parameters:
TIMEOUT_CYCLES, 255, number of WAIT cycles without mem_rvalid before a fault is forced (used only with DMEM_TIMEOUT_EN)

Ports:
clock  in  1  core clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  access request from execute
req_ready  out  1  request accepted this cycle when high with req_valid
req_load  in  1  request is a load
req_store  in  1  request is a store
req_op  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  in  32  byte address
req_byteenable  in  4  lane enables; 0 means misaligned, do not access
req_wdata  in  32  store data, unshifted (rs2)
flush  in  1  pipeline flush
mem_valid  out  1  bus request valid
mem_ready  in  1  bus accepts request
mem_addr  out  32  word address, bits [1:0]=0
mem_wstrb  out  4  write strobes; 0 for loads
mem_wdata  out  32  lane-replicated store data
mem_rvalid  in  1  bus response valid
mem_rdata  in  32  read data word
mem_err  in  1  bus error, qualified by mem_rvalid
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data; 0 for stores
resp_exception  out  1  access fault
resp_ecause  out  4  5 load access fault, 7 store access fault
resp_etval  out  32  faulting byte address
busy  out  1  high in REQ or WAIT

Behaviour:
- States: IDLE, REQ, WAIT. Reset, asynchronous: state IDLE, all outputs 0, except req_ready, which is 1 once out of reset while in IDLE.
- req_ready = (state==IDLE) & ~flush.
- Accept when req_valid & req_ready & (req_load|req_store) & req_byteenable!=0.
  - Capture mem_addr={req_addr[31:2],2'b00}.
  - Capture mem_wstrb = req_store ? req_byteenable : 0.
  - Capture mem_wdata = SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata.
  - Capture req_op, req_addr (full), load/store flag.
  - Next state REQ.
- Requests with byteenable 0, or with neither load nor store: consumed, no bus access, no response, stay IDLE.
- REQ: mem_valid=1; all mem_* held stable until mem_ready. On mem_valid&mem_ready, go to WAIT next cycle. mem_valid is registered, so the earliest bus handshake is 1 cycle after accept.
- WAIT: on mem_rvalid, register the response and go to IDLE. resp_valid=1 for exactly the next cycle. Minimum accept-to-resp_valid = 3 cycles with mem_ready and mem_rvalid both immediate.
- Load extract: lane = mem_rdata >> (8*addr[1:0]).
  - B: sign-extend [7:0]; BU: zero-extend [7:0].
  - H: sign-extend [15:0]; HU: zero-extend [15:0].
  - W: full word.
- mem_err with mem_rvalid: resp_exception=1, ecause 5 (load) or 7 (store), etval = captured byte address, resp_rdata=0.
- resp_exception, resp_ecause, resp_etval, resp_rdata are 0 whenever resp_valid=0.
- mem_rvalid outside WAIT is ignored.
- Flush:
  - IDLE: blocks acceptance that cycle.
  - REQ with mem_ready=0: drop mem_valid, go to IDLE, no response.
  - REQ with mem_ready=1: handshake completes; treat as flush in WAIT.
  - WAIT: set a suppress flag; stay in WAIT until mem_rvalid, then go to IDLE with no resp_valid.
- Back-to-back: a new request may be accepted in the cycle resp_valid is high, since state is IDLE.

Optional Feature:
DMEM_TIMEOUT_EN:
- Defined: an 8+ bit counter runs in WAIT. When it reaches TIMEOUT_CYCLES without mem_rvalid, complete with access fault exactly as for mem_err and go to IDLE. A late mem_rvalid is ignored. The counter clears on entering WAIT and on reset.
- Undefined: no counter; WAIT persists indefinitely.

Test Plan:
- LB addr 0x103, be 4'h8, mem_rdata 0x80FF_1234, immediate ready/rvalid -> mem_addr 0x100, mem_wstrb 0, resp_rdata 0xFFFF_FF80, resp_valid 3 cycles after accept.
- SH addr 0x202, be 4'hC, wdata 0x0000_ABCD -> mem_wdata 0xABCD_ABCD, mem_wstrb 4'hC, resp_rdata 0, no exception.
- LHU addr 0x2, mem_ready held low 4 cycles -> mem_valid and mem_addr stable 4 cycles; with rdata 0x9876_0000, resp_rdata 0x0000_9876.
- LW addr 0x40 with mem_err=1 on rvalid -> resp_exception 1, ecause 5, etval 0x40; SW variant -> ecause 7.
- flush in WAIT, then rvalid 2 cycles later -> no resp_valid, IDLE, next request accepted; flush in REQ with mem_ready=0 -> mem_valid drops next cycle.
- req_byteenable 0 load -> no mem_valid, no resp_valid; with DMEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, no rvalid -> fault response ecause 5 after 4 WAIT cycles.
